stereo_fb_write_arbiter: RTL and testbench
==========================================

// Module: stereo_fb_write_arbiter
// PURPOSE
//  Shares the single write port of the 640x480 stereo debug frame buffer between the left and right
//  camera pixel streams. Round-robin grant, at most one write per cycle. Right-camera pixels are
//  placed side-by-side (x offset ROW_SZ). Frames are synchronised per stream: each stream waits for
//  its SOF, writes one full frame, then holds until the other stream also finishes the frame.
// PARAMETERS
//  ROW_SZ  320  pixels per camera line; also the x offset for requester 1 (2*ROW_SZ <= 640)
//  COL_SZ  240  lines per camera frame (COL_SZ <= 480)
// PORTS
//  clk          in   1   system clock; the frame buffer write port uses this clock
//  reset        in   1   asynchronous, active-high reset
//  enable       in   1   capture enable; gates frame start only
//  rq0_x        in   10  left pixel x
//  rq0_y        in   10  left pixel y
//  rq0_val      in   8   left pixel value
//  rq0_sof      in   1   left start-of-frame flag (valid with x=0, y=0)
//  rq0_valid    in   1   left beat valid
//  rq0_ready    out  1   left beat accepted this cycle (transfer = valid & ready)
//  rq1_*        --   --  right stream; same set and widths as rq0_*
//  wr_x         out  10  frame buffer write x
//  wr_y         out  10  frame buffer write y
//  wr_val       out  8   frame buffer write data
//  wr_en        out  1   frame buffer write enable
//  frame_done   out  1   one-cycle pulse when both streams have completed a frame
//  drop_cnt     out  16  saturating count of accepted-but-discarded out-of-range beats
// BEHAVIOUR
//  Reset: wr_x/wr_y/wr_val/drop_cnt = 0; wr_en, frame_done = 0; both stream FSMs to IDLE;
//   rr_ptr = 0 (requester 0 has priority).
//  Per-stream FSM:
//   IDLE:   beat with sof=0, or any beat while enable=0: ready=1 combinationally, discarded.
//           Beat with sof=1 and enable=1 contends for the grant. When granted, it is written and
//           the FSM goes to ACTIVE.
//   ACTIVE: every valid beat contends for the grant. A granted in-range beat is written.
//           A granted beat with x>=ROW_SZ or y>=COL_SZ is consumed, not written; drop_cnt += 1,
//           saturating at 0xFFFF. A granted beat with x=ROW_SZ-1 and y=COL_SZ-1 is written and
//           the FSM goes to DONE. A sof=1 beat in ACTIVE is handled as an ordinary pixel.
//   DONE:   ready=0. When both streams are in DONE, frame_done pulses for 1 cycle and both go to
//           IDLE on the same edge.
//  Arbitration (combinational):
//   - Only one contending stream: that stream is granted.
//   - Both contending: the stream selected by rr_ptr is granted; rr_ptr <= other stream.
//   - rr_ptr updates only on contended grants.
//  Handshake: ready is combinational from valid, state and rr_ptr. No ready-to-valid dependency is
//   required of the sources; a beat held with ready=0 stays valid unchanged.
//  Output register, latency 1 cycle:
//   - Transfer of a beat to be written at edge N gives wr_en=1 after edge N, with
//     wr_x = x (+ROW_SZ for rq1), wr_y = y, wr_val = val.
//   - Otherwise wr_en=0 and wr_x/wr_y/wr_val hold their last values.
//   - The x offset add is 10-bit with no overflow (guaranteed by range check + parameter rule).
//  enable deassert mid-frame: ACTIVE/DONE streams complete normally; only IDLE->ACTIVE is blocked.
//  Reset mid-frame: immediate return to reset state; no further wr_en until a new SOF.
// TESTING
//  1 Reset with rq0/rq1 valid high -> wr_en=0, ready=0 for SOF beats until reset drops; drop_cnt=0.
//  2 rq0 only, 320x240 frame, valid every cycle, enable=1 -> 76800 writes, wr_x=x, 1-cycle latency,
//    rq0 DONE, no frame_done until rq1 completes.
//  3 Both streams valid every cycle, SOF together -> grants alternate 0,1,0,1; rq1 pixel (5,7)
//    writes wr_x=325, wr_y=7; frame_done 1 cycle after the later last pixel, both back to IDLE.
//  4 rq0 beats before SOF and with enable=0 -> ready=1, no wr_en; SOF with enable=1 -> write (0,0).
//  5 rq1 ACTIVE beat x=400 -> consumed, no write, drop_cnt 0->1; force drop_cnt=0xFFFF ->
//    stays 0xFFFF.
//  6 Assert reset mid-frame at pixel (100,50) -> wr_en low next cycle; non-SOF beats after
//    release are discarded.

Source files
------------

// File: rtl/stereo_fb_write_arbiter_if.sv
// Pixel beat stream from one camera into the frame buffer write arbiter.
// Latency: none, signal bundle only.
// Backpressure: a beat moves when valid & ready; the source holds it unchanged while ready=0.
//
// Signals:
//   x, y   pixel coordinate within the camera frame (10 bits each)
//   val    pixel value (8 bits)
//   sof    start-of-frame flag, meaningful with x=0, y=0
//   valid  beat present
//   ready  beat accepted this cycle
// Modports: master = pixel source, slave = arbiter side.
interface stereo_fb_write_arbiter_if;
   logic [9:0] x;
   logic [9:0] y;
   logic [7:0] val;
   logic       sof;
   logic       valid;
   logic       ready;

   modport master (output x, y, val, sof, valid, input ready);
   modport slave  (input x, y, val, sof, valid, output ready);
endinterface

// File: rtl/stereo_fb_write_arbiter.sv
// Round-robin sharing of the stereo debug frame buffer write port between left/right pixel streams.
// Latency: 1 cycle from accepted beat to registered wr_* outputs.
// Backpressure: ready is combinational; the losing contender and DONE streams see ready=0.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   enable              capture enable, gates only the start of a new frame
//   rq0, rq1            left / right pixel streams (slave side)
//   wr_x, wr_y, wr_val  frame buffer write address and data (right stream offset by ROW_SZ in x)
//   wr_en               frame buffer write strobe
//   frame_done          one-cycle pulse once both streams have completed a frame
//   drop_cnt            saturating count of accepted out-of-range beats
module stereo_fb_write_arbiter #(
   parameter int ROW_SZ = 320,
   parameter int COL_SZ = 240
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   stereo_fb_write_arbiter_if.slave  rq0,
   stereo_fb_write_arbiter_if.slave  rq1,
   output logic [9:0]                wr_x,
   output logic [9:0]                wr_y,
   output logic [7:0]                wr_val,
   output logic                      wr_en,
   output logic                      frame_done,
   output logic [15:0]               drop_cnt
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic [9:0] ROW_LIM = 10'(ROW_SZ);
   localparam logic [9:0] COL_LIM = 10'(COL_SZ);
   localparam logic [9:0] X_LAST  = 10'(ROW_SZ - 1);
   localparam logic [9:0] Y_LAST  = 10'(COL_SZ - 1);

   logic [1:0] state [2];
   logic [9:0] px    [2];
   logic [9:0] py    [2];
   logic [7:0] pval  [2];
   logic [1:0] pvld;
   logic [1:0] psof;

   logic [1:0] contend;
   logic [1:0] grant;
   logic [1:0] discard;
   logic [1:0] in_rng;
   logic [1:0] last_px;
   logic [1:0] wr_go;
   logic [1:0] drop_go;
   logic       rr_ptr;     // 0: rq0 wins a tie, 1: rq1 wins a tie
   logic       both_done;

   assign px[0]   = rq0.x;
   assign py[0]   = rq0.y;
   assign pval[0] = rq0.val;
   assign pvld[0] = rq0.valid;
   assign psof[0] = rq0.sof;
   assign px[1]   = rq1.x;
   assign py[1]   = rq1.y;
   assign pval[1] = rq1.val;
   assign pvld[1] = rq1.valid;
   assign psof[1] = rq1.sof;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         // IDLE only competes for the port with a frame start while capture is enabled
         contend[i] = pvld[i] &&
                      ((state[i] == ST_IDLE && psof[i] && enable) || state[i] == ST_ACTIVE);
         // everything else arriving in IDLE is swallowed without touching the port
         discard[i] = (state[i] == ST_IDLE) && !(psof[i] && enable);
         in_rng[i]  = (px[i] < ROW_LIM) && (py[i] < COL_LIM);
         last_px[i] = (px[i] == X_LAST) && (py[i] == Y_LAST);
      end
   end

   // Nothing is accepted while reset is held, so sources never lose a beat to reset.
   assign grant[0] = !reset && contend[0] && (!contend[1] || !rr_ptr);
   assign grant[1] = !reset && contend[1] && (!contend[0] ||  rr_ptr);

   assign rq0.ready = !reset && (discard[0] || grant[0]);
   assign rq1.ready = !reset && (discard[1] || grant[1]);

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         // the SOF beat that opens a frame is always written
         wr_go[i]   = grant[i] && (state[i] == ST_IDLE || in_rng[i]);
         drop_go[i] = grant[i] && (state[i] == ST_ACTIVE) && !in_rng[i];
      end
   end

   assign both_done = (state[0] == ST_DONE) && (state[1] == ST_DONE);

   // Per-stream frame FSMs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state[0] <= ST_IDLE;
         state[1] <= ST_IDLE;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (both_done)
               state[i] <= ST_IDLE;
            else if (grant[i] && in_rng[i] && last_px[i])
               state[i] <= ST_DONE;
            else if (grant[i])
               state[i] <= ST_ACTIVE;
         end
      end
   end

   // Arbitration pointer, write port register, frame pulse and drop counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr     <= 1'b0;
         wr_x       <= '0;
         wr_y       <= '0;
         wr_val     <= '0;
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         // only a real tie moves the pointer; it then favours the stream that lost
         if (contend[0] && contend[1])
            rr_ptr <= grant[0];

         wr_en <= |wr_go;
         if (wr_go[0]) begin
            wr_x   <= px[0];
            wr_y   <= py[0];
            wr_val <= pval[0];
         end else if (wr_go[1]) begin
            // right image sits beside the left one; range check keeps this inside 10 bits
            wr_x   <= px[1] + ROW_LIM;
            wr_y   <= py[1];
            wr_val <= pval[1];
         end

         frame_done <= both_done;

         if ((|drop_go) && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_stereo_fb_write_arbiter.sv
// Directed bench for stereo_fb_write_arbiter: reset, single and dual stream frames, IDLE discard,
// range drops with counter saturation, and reset mid-frame.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-2 units after it.
module tb_stereo_fb_write_arbiter;
   localparam int ROW_SZ = 320;
   localparam int COL_SZ = 4;
   localparam int NPIX   = ROW_SZ * COL_SZ;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [9:0]  wr_x;
   logic [9:0]  wr_y;
   logic [7:0]  wr_val;
   logic        wr_en;
   logic        frame_done;
   logic [15:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   stereo_fb_write_arbiter_if rq0_if ();
   stereo_fb_write_arbiter_if rq1_if ();

   stereo_fb_write_arbiter #(.ROW_SZ(ROW_SZ), .COL_SZ(COL_SZ)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .rq0        (rq0_if),
      .rq1        (rq1_if),
      .wr_x       (wr_x),
      .wr_y       (wr_y),
      .wr_val     (wr_val),
      .wr_en      (wr_en),
      .frame_done (frame_done),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int s, input logic v, input logic sf,
                      input logic [9:0] x, input logic [9:0] y, input logic [7:0] val);
      if (s == 0) begin
         rq0_if.valid = v; rq0_if.sof = sf; rq0_if.x = x; rq0_if.y = y; rq0_if.val = val;
      end else begin
         rq1_if.valid = v; rq1_if.sof = sf; rq1_if.x = x; rq1_if.y = y; rq1_if.val = val;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drv(0, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);
      drv(1, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [7:0] pv(input logic [9:0] x, input logic [9:0] y);
      return x[7:0] + {y[4:0], 3'b000};
   endfunction

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] ex, ey;
      logic [7:0] ev;
      logic       t0, t1;
      int         a, b;

      // 1: reset with both streams offering SOF beats
      reset  = 1'b1;
      enable = 1'b1;
      drv(0, 1'b1, 1'b1, 10'd0, 10'd0, 8'h12);
      drv(1, 1'b1, 1'b1, 10'd0, 10'd0, 8'h34);
      #2;
      chk("t1_rdy", 32'({rq0_if.ready, rq1_if.ready}), 32'd0);
      chk("t1_out", 32'({frame_done, wr_en, wr_y, wr_x, wr_val}), 32'd0);
      chk("t1_drop", 32'(drop_cnt), 32'd0);
      tick();
      tick();
      chk("t1_rdy_hold", 32'({rq0_if.ready, rq1_if.ready}), 32'd0);
      chk("t1_wren_hold", 32'(wr_en), 32'd0);
      drv(0, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);
      drv(1, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);
      reset = 1'b0;
      tick();

      // 2: left stream alone, one full frame
      for (int p = 0; p < NPIX; p++) begin
         ex = 10'(p % ROW_SZ);
         ey = 10'(p / ROW_SZ);
         drv(0, 1'b1, p == 0, ex, ey, pv(ex, ey));
         #1;
         chk("t2_rdy", 32'(rq0_if.ready), 32'd1);
         tick();
         chk("t2_wr", 32'({frame_done, wr_en, wr_y, wr_x, wr_val}),
             32'({1'b0, 1'b1, ey, ex, pv(ex, ey)}));
      end
      drv(0, 1'b1, 1'b1, 10'd0, 10'd0, 8'h77);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t2_done_rdy", 32'(rq0_if.ready), 32'd0);
         tick();
         chk("t2_no_fd", 32'({frame_done, wr_en}), 32'd0);
      end
      do_reset();

      // 3: both streams every cycle, SOF together
      a = 0;
      b = 0;
      for (int k = 0; k < 2 * NPIX; k++) begin
         if (a < NPIX) drv(0, 1'b1, a == 0, 10'(a % ROW_SZ), 10'(a / ROW_SZ),
                           pv(10'(a % ROW_SZ), 10'(a / ROW_SZ)));
         else          drv(0, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);
         if (b < NPIX) drv(1, 1'b1, b == 0, 10'(b % ROW_SZ), 10'(b / ROW_SZ),
                           ~pv(10'(b % ROW_SZ), 10'(b / ROW_SZ)));
         else          drv(1, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);
         #1;
         chk("t3_rdy", 32'({rq0_if.ready, rq1_if.ready}), (k % 2 == 0) ? 32'd2 : 32'd1);
         t0 = rq0_if.valid & rq0_if.ready;
         t1 = rq1_if.valid & rq1_if.ready;
         tick();
         ex = 10'((k / 2) % ROW_SZ);
         ey = 10'((k / 2) / ROW_SZ);
         ev = pv(ex, ey);
         if (k % 2 == 1) begin
            ev = ~ev;
            ex = ex + 10'(ROW_SZ);
         end
         chk("t3_wr", 32'({frame_done, wr_en, wr_y, wr_x, wr_val}),
             32'({1'b0, 1'b1, ey, ex, ev}));
         if (k % 2 == 1 && ex == 10'd325 && ey == 10'd3)
            chk("t3_px53", 32'({wr_x, wr_y}), 32'({10'd325, 10'd3}));
         if (t0) a++;
         if (t1) b++;
      end
      tick();
      chk("t3_fd", 32'({frame_done, wr_en}), 32'd2);
      drv(0, 1'b1, 1'b0, 10'd4, 10'd0, 8'd1);
      drv(1, 1'b1, 1'b0, 10'd4, 10'd0, 8'd2);
      #1;
      chk("t3_idle_rdy", 32'({rq0_if.ready, rq1_if.ready}), 32'd3);
      tick();
      chk("t3_fd_end", 32'({frame_done, wr_en}), 32'd0);
      do_reset();

      // 4: IDLE discards non-SOF beats and SOF while disabled
      enable = 1'b1;
      drv(0, 1'b1, 1'b0, 10'd3, 10'd0, 8'h21);
      #1;
      chk("t4_nosof_rdy", 32'(rq0_if.ready), 32'd1);
      tick();
      chk("t4_nosof_wr", 32'(wr_en), 32'd0);
      enable = 1'b0;
      drv(0, 1'b1, 1'b1, 10'd0, 10'd0, 8'h22);
      #1;
      chk("t4_dis_rdy", 32'(rq0_if.ready), 32'd1);
      tick();
      chk("t4_dis_wr", 32'(wr_en), 32'd0);
      enable = 1'b1;
      drv(0, 1'b1, 1'b1, 10'd0, 10'd0, 8'hAA);
      #1;
      chk("t4_sof_rdy", 32'(rq0_if.ready), 32'd1);
      tick();
      chk("t4_sof_wr", 32'({wr_en, wr_x, wr_y, wr_val}), 32'({1'b1, 10'd0, 10'd0, 8'hAA}));
      drv(0, 1'b1, 1'b0, 10'd1, 10'd0, 8'h55);
      tick();
      chk("t4_act_wr", 32'({wr_en, wr_x, wr_y, wr_val}), 32'({1'b1, 10'd1, 10'd0, 8'h55}));
      drv(0, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);

      // 5: right stream out-of-range beats and drop counter saturation
      drv(1, 1'b1, 1'b1, 10'd0, 10'd0, 8'h11);
      tick();
      chk("t5_sof_wr", 32'({wr_en, wr_x, wr_y, wr_val}), 32'({1'b1, 10'd320, 10'd0, 8'h11}));
      drv(1, 1'b1, 1'b0, 10'd400, 10'd0, 8'h12);
      #1;
      chk("t5_drop_rdy", 32'(rq1_if.ready), 32'd1);
      tick();
      chk("t5_drop1", 32'({wr_en, wr_x, drop_cnt}), 32'({1'b0, 10'd320, 16'd1}));
      drv(1, 1'b1, 1'b0, 10'd0, 10'd4, 8'h13);
      tick();
      chk("t5_drop_y", 32'({wr_en, drop_cnt}), 32'({1'b0, 16'd2}));
      drv(1, 1'b1, 1'b0, 10'd400, 10'd0, 8'h14);
      for (int k = 0; k < 65532; k++) tick();
      chk("t5_fffe", 32'(drop_cnt), 32'h0000_FFFE);
      tick();
      chk("t5_ffff", 32'(drop_cnt), 32'h0000_FFFF);
      tick();
      chk("t5_sat", 32'({wr_en, drop_cnt}), 32'({1'b0, 16'hFFFF}));
      do_reset();

      // 6: reset mid-frame; enable dropped after SOF must not stop the frame
      chk("t6_drop_clr", 32'(drop_cnt), 32'd0);
      enable = 1'b1;
      for (int p = 0; p <= 2 * ROW_SZ + 100; p++) begin
         ex = 10'(p % ROW_SZ);
         ey = 10'(p / ROW_SZ);
         drv(0, 1'b1, p == 0, ex, ey, pv(ex, ey));
         tick();
         enable = 1'b0;
      end
      chk("t6_px100_2", 32'({wr_en, wr_x, wr_y, wr_val}),
          32'({1'b1, 10'd100, 10'd2, pv(10'd100, 10'd2)}));
      drv(0, 1'b1, 1'b0, 10'd101, 10'd2, 8'h5A);
      reset = 1'b1;
      #1;
      chk("t6_rst_wren", 32'({wr_en, rq0_if.ready}), 32'd0);
      tick();
      reset  = 1'b0;
      enable = 1'b1;
      #1;
      chk("t6_discard_rdy", 32'(rq0_if.ready), 32'd1);
      tick();
      chk("t6_discard_wr", 32'(wr_en), 32'd0);
      drv(0, 1'b1, 1'b0, 10'd102, 10'd2, 8'h5B);
      tick();
      chk("t6_discard_wr2", 32'(wr_en), 32'd0);
      drv(0, 1'b1, 1'b1, 10'd0, 10'd0, 8'h3C);
      tick();
      chk("t6_new_sof", 32'({wr_en, wr_x, wr_y, wr_val}), 32'({1'b1, 10'd0, 10'd0, 8'h3C}));
      drv(0, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
